multiplier_datapath_taint_track: RTL

Shift-add multiplier datapath that executes the load/clear/add/shift commands issued by the sequential multiplier control FSM. It returns the multiplier register bits the FSM branches on, and the final product.
Every register carries a bitwise taint shadow, so information flow is tracked through data operands and through tainted control strobes.
A taint-kill input clears all shadow state, matching the control-side kill.

---
 rtl/multiplier_taint_pkg.sv | 20 ++
 rtl/multiplier_taint_adder.sv | 35 +++
 rtl/multiplier_datapath_taint_track.sv | 120 ++++++++++++
 3 files changed

// File: rtl/multiplier_taint_pkg.sv
// rtl/multiplier_taint_pkg.sv - shared constants and control-strobe taint rule for the taint-tracked multiplier datapath
package multiplier_taint_pkg;

   localparam int DATA_WIDTH = 4;
   localparam int RS_WIDTH   = 2*DATA_WIDTH + 1;

   // Taint contributed by a tainted strobe: the bit is tainted if either the
   // held or the candidate value is tainted, or if the strobe decides between
   // two different values. Returns 0 when the strobe itself is untainted.
   function automatic logic taint_ctrl_merge(
      input logic old_v,
      input logic new_v,
      input logic old_t,
      input logic new_t,
      input logic strobe_t
   );
      return strobe_t & (old_t | new_t | (old_v ^ new_v));
   endfunction

endpackage

// File: rtl/multiplier_taint_adder.sv
// rtl/multiplier_taint_adder.sv - W-bit add with carry-out and taint; TAINT_PRECISE_ADD_EN selects carry-chain taint
module multiplier_taint_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_a_t,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_b_t,
   output logic [W:0]   o_sum,
   output logic [W:0]   o_sum_t
);

   logic [W-1:0] w_op_t;

   assign o_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_op_t = i_a_t | i_b_t;

`ifdef TAINT_PRECISE_ADD_EN
   logic [W-1:0] w_prefix_t;

   // Sum bit k can only be influenced through the carry chain by bits at or below k.
   always_comb begin
      w_prefix_t    = '0;
      w_prefix_t[0] = w_op_t[0];
      for (int k = 1; k < W; k++) begin
         w_prefix_t[k] = w_prefix_t[k-1] | w_op_t[k];
      end
   end

   assign o_sum_t = {w_prefix_t[W-1], w_prefix_t};
`else
   assign o_sum_t = {(W+1){|w_op_t}};
`endif

endmodule

// File: rtl/multiplier_datapath_taint_track.sv
// rtl/multiplier_datapath_taint_track.sv - shift-add multiplier datapath with bitwise taint shadows (option macro TAINT_PRECISE_ADD_EN)
module multiplier_datapath_taint_track #(
   parameter int WIDTH = multiplier_taint_pkg::DATA_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dp_t_kill,
   input  logic [WIDTH-1:0]   multiplicand_in,
   input  logic [WIDTH-1:0]   multiplicand_in_t,
   input  logic [WIDTH-1:0]   multiplier_in,
   input  logic [WIDTH-1:0]   multiplier_in_t,
   input  logic               mdld,
   input  logic               mdld_t,
   input  logic               mrld,
   input  logic               mrld_t,
   input  logic               rsclear,
   input  logic               rsclear_t,
   input  logic               rsload,
   input  logic               rsload_t,
   input  logic               rsshr,
   input  logic               rsshr_t,
   output logic [WIDTH-1:0]   multiplierReg,
   output logic [WIDTH-1:0]   multiplierReg_t,
   output logic [2*WIDTH-1:0] product,
   output logic [2*WIDTH-1:0] product_t
);

   import multiplier_taint_pkg::*;

   localparam int RSW = 2*WIDTH + 1;

   logic [WIDTH-1:0] r_md, r_md_t, r_mr, r_mr_t;
   logic [RSW-1:0]   r_rs, r_rs_t;

   logic [WIDTH-1:0] w_md_nxt, w_md_t_nxt, w_mr_nxt, w_mr_t_nxt;
   logic [WIDTH:0]   w_sum, w_sum_t;
   logic [RSW-1:0]   w_ld_v, w_ld_t, w_s1_v, w_s1_t;
   logic [RSW-1:0]   w_sh_v, w_sh_t, w_s2_v, w_s2_t;
   logic [RSW-1:0]   w_rs_nxt, w_rs_t_nxt;

   multiplier_taint_adder #(.W(WIDTH)) u_adder (
      .i_a     (r_rs[2*WIDTH-1:WIDTH]),
      .i_a_t   (r_rs_t[2*WIDTH-1:WIDTH]),
      .i_b     (r_md),
      .i_b_t   (r_md_t),
      .o_sum   (w_sum),
      .o_sum_t (w_sum_t)
   );

   // Operand registers: plain load, widened by strobe taint where the strobe is tainted.
   always_comb begin
      w_md_nxt   = mdld ? multiplicand_in   : r_md;
      w_md_t_nxt = mdld ? multiplicand_in_t : r_md_t;
      w_mr_nxt   = mrld ? multiplier_in     : r_mr;
      w_mr_t_nxt = mrld ? multiplier_in_t   : r_mr_t;
      for (int i = 0; i < WIDTH; i++) begin
         w_md_t_nxt[i] = w_md_t_nxt[i] |
            taint_ctrl_merge(r_md[i], multiplicand_in[i], r_md_t[i], multiplicand_in_t[i], mdld_t);
         w_mr_t_nxt[i] = w_mr_t_nxt[i] |
            taint_ctrl_merge(r_mr[i], multiplier_in[i], r_mr_t[i], multiplier_in_t[i], mrld_t);
      end
   end

   // Result register as a chain add -> shift -> clear; each stage's strobe taint
   // compares the value entering that stage with the value the stage would produce.
   always_comb begin
      w_ld_v = {w_sum,   r_rs[WIDTH-1:0]};
      w_ld_t = {w_sum_t, r_rs_t[WIDTH-1:0]};
      w_s1_v = rsload ? w_ld_v : r_rs;
      w_s1_t = rsload ? w_ld_t : r_rs_t;
      for (int i = 0; i < RSW; i++) begin
         w_s1_t[i] = w_s1_t[i] | taint_ctrl_merge(r_rs[i], w_ld_v[i], r_rs_t[i], w_ld_t[i], rsload_t);
      end

      w_sh_v = w_s1_v >> 1;
      w_sh_t = w_s1_t >> 1;
      w_s2_v = rsshr ? w_sh_v : w_s1_v;
      w_s2_t = rsshr ? w_sh_t : w_s1_t;
      for (int i = 0; i < RSW; i++) begin
         w_s2_t[i] = w_s2_t[i] | taint_ctrl_merge(w_s1_v[i], w_sh_v[i], w_s1_t[i], w_sh_t[i], rsshr_t);
      end

      w_rs_nxt   = rsclear ? '0 : w_s2_v;
      w_rs_t_nxt = rsclear ? '0 : w_s2_t;
      for (int i = 0; i < RSW; i++) begin
         w_rs_t_nxt[i] = w_rs_t_nxt[i] | taint_ctrl_merge(w_s2_v[i], 1'b0, w_s2_t[i], 1'b0, rsclear_t);
      end
   end

   // State update: reset wins over everything; kill clears only the shadows.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_md   <= '0;
         r_md_t <= '0;
         r_mr   <= '0;
         r_mr_t <= '0;
         r_rs   <= '0;
         r_rs_t <= '0;
      end else begin
         r_md <= w_md_nxt;
         r_mr <= w_mr_nxt;
         r_rs <= w_rs_nxt;
         if (dp_t_kill) begin
            r_md_t <= '0;
            r_mr_t <= '0;
            r_rs_t <= '0;
         end else begin
            r_md_t <= w_md_t_nxt;
            r_mr_t <= w_mr_t_nxt;
            r_rs_t <= w_rs_t_nxt;
         end
      end
   end

   assign multiplierReg   = r_mr;
   assign multiplierReg_t = r_mr_t;
   assign product         = r_rs[2*WIDTH-1:0];
   assign product_t       = r_rs_t[2*WIDTH-1:0];

endmodule
